nes_pio_in_edge: RTL and testbench



---
 rtl/nes_pio_pkg.sv | 15 +
 rtl/nes_pio_in_edge_if.sv | 18 +
 rtl/nes_pio_sync.sv | 29 ++
 rtl/nes_pio_in_edge.sv | 102 ++++++++++
 tb/tb_nes_pio_in_edge.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nes_pio_pkg.sv
// Shared constants for the NES PIO family: Avalon register map and edge-capture modes.
package nes_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nes_pio_in_edge_if.sv
// Avalon-MM slave bus bundle shared by the NES PIO blocks.
interface nes_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nes_pio_sync.sv
// Multi-flop synchroniser for an asynchronous bus, WIDTH bits by STAGES deep.
module nes_pio_sync #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/nes_pio_in_edge.sv
// Avalon-MM input PIO: synchronised level register, per-bit edge capture,
// interrupt mask and a level-sensitive registered IRQ.
module nes_pio_in_edge
    import nes_pio_pkg::*;
#(
    parameter int               WIDTH       = 24,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    nes_pio_in_edge_if.slave    bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev_q,     prev_d;
    logic [2:0]       prime_q,    prime_d;
    logic [WIDTH-1:0] edgecap_q,  edgecap_d;
    logic [WIDTH-1:0] irqmask_q,  irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q,      irq_d;

    logic             primed;
    logic             wr_en;
    pio_addr_e        addr;
    logic [WIDTH-1:0] rise, fall, ev, clr;
    logic             unused_wdata;

    nes_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync)
    );

    assign unused_wdata = ^bus.writedata;

    always_comb begin
        addr    = pio_addr_e'(bus.address);
        wr_en   = bus.chipselect & ~bus.write_n;
        primed  = (prime_q == PRIME_DONE);
        prime_d = primed ? prime_q : prime_q + 3'd1;
        prev_d  = sync;

        // Suppress edges until the synchroniser and prev hold post-reset samples.
        rise = sync & ~prev_q;
        fall = ~sync & prev_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            ev = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            ev = rise | fall;
        end else begin
            ev = rise;
        end
        if (!primed) begin
            ev = '0;
        end

        clr = (wr_en && addr == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~clr) | ev;
        irqmask_d = (wr_en && addr == ADDR_MASK) ? bus.writedata[WIDTH-1:0] : irqmask_q;
        irq_d     = |(edgecap_q & irqmask_q);

        readdata_d = '0;
        case (addr)
            ADDR_DATA: readdata_d[WIDTH-1:0] = sync;
            ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            prime_q    <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= RESET_MASK;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prime_q    <= prime_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_nes_pio_in_edge.sv
// Self-checking bench for nes_pio_in_edge: register table, directed edge/IRQ
// sequences, a priming/reset sequence and randomized traffic against a history model.
module tb_nes_pio_in_edge;
    import nes_pio_pkg::*;

    localparam int W   = 24;
    localparam int S_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a_n, rst_b_n;
    logic [W-1:0] in_a, in_b;
    logic         irq_a, irq_b;

    nes_pio_in_edge_if bus_a ();
    nes_pio_in_edge_if bus_b ();

    nes_pio_in_edge #(
        .WIDTH(W), .SYNC_STAGES(S_A), .EDGE_TYPE(EDGE_RISE), .RESET_MASK(24'h0)
    ) dut_a (
        .clk(clk), .reset_n(rst_a_n), .bus(bus_a.slave), .in_port(in_a), .irq(irq_a)
    );

    nes_pio_in_edge #(
        .WIDTH(W), .SYNC_STAGES(3), .EDGE_TYPE(EDGE_ANY), .RESET_MASK(24'h0)
    ) dut_b (
        .clk(clk), .reset_n(rst_b_n), .bus(bus_b.slave), .in_port(in_b), .irq(irq_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: the input sample taken at every clock since reset is kept
    // in a history; sync and prev are simply older entries of that history.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_cap, m_mask;
    logic         m_irq;
    logic [31:0]  m_rd;
    int           m_k;

    function automatic logic [W-1:0] hist_get(input int j);
        if (j - 1 < m_hist.size()) return m_hist[j-1];
        return '0;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_cap = '0; m_mask = '0; m_irq = 1'b0; m_rd = '0; m_k = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] sync_o, prev_o, ev;
        logic wr;
        m_k++;
        sync_o = hist_get(S_A);
        prev_o = hist_get(S_A + 1);
        ev = ((m_k - 1) >= S_A + 1) ? (sync_o & ~prev_o) : '0;
        wr = bus_a.chipselect & ~bus_a.write_n;
        case (bus_a.address)
            2'd0:    m_rd = {8'h0, sync_o};
            2'd2:    m_rd = {8'h0, m_mask};
            2'd3:    m_rd = {8'h0, m_cap};
            default: m_rd = '0;
        endcase
        m_irq = |(m_cap & m_mask);
        if (wr && bus_a.address == 2'd3) m_cap = m_cap & ~bus_a.writedata[W-1:0];
        m_cap = m_cap | ev;
        if (wr && bus_a.address == 2'd2) m_mask = bus_a.writedata[W-1:0];
        m_hist.push_front(in_a);
        if (m_hist.size() > 8) void'(m_hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_a_n) model_step();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic [1:0] a, input logic wr, input logic [31:0] wd);
        bus_a.address    = a;
        bus_a.chipselect = 1'b1;
        bus_a.write_n    = ~wr;
        bus_a.writedata  = wd;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{2'd0, 1'b0, 32'h0,        32'h00FFFFFF, 1'b0};
        vt[1]  = '{2'd3, 1'b0, 32'h0,        32'h00000000, 1'b0};
        vt[2]  = '{2'd1, 1'b0, 32'h0,        32'h00000000, 1'b0};
        vt[3]  = '{2'd2, 1'b0, 32'h0,        32'h00000000, 1'b0};
        vt[4]  = '{2'd2, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vt[5]  = '{2'd2, 1'b0, 32'h0,        32'h00FFFFFF, 1'b0};
        vt[6]  = '{2'd0, 1'b1, 32'h0,        32'h00FFFFFF, 1'b0};
        vt[7]  = '{2'd0, 1'b0, 32'h0,        32'h00FFFFFF, 1'b0};
        vt[8]  = '{2'd1, 1'b1, 32'h12345678, 32'h00000000, 1'b0};
        vt[9]  = '{2'd1, 1'b0, 32'h0,        32'h00000000, 1'b0};
        vt[10] = '{2'd2, 1'b1, 32'h0,        32'h00FFFFFF, 1'b0};
        vt[11] = '{2'd2, 1'b0, 32'h0,        32'h00000000, 1'b0};

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        in_a = 24'hFFFFFF; in_b = '0;
        bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
        bus_b.address = 2'd3; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
        model_reset();

        // Reset with inputs high, release, settle
        repeat (2) @(negedge clk);
        check("rst_rd", bus_a.readdata, 32'h0);
        check("rst_irq", {31'h0, irq_a}, 32'h0);
        rst_a_n = 1'b1;
        repeat (10) tick();

        // Register map table
        for (int i = 0; i < 12; i++) begin
            drive_a(vt[i].addr, vt[i].wr, vt[i].wd);
            tick();
            $display("vec %0d addr=%0d wr=%0b wd=%h rd=%h irq=%0b", i, vt[i].addr, vt[i].wr,
                     vt[i].wd, bus_a.readdata, irq_a);
            check($sformatf("vec%0d_rd", i), bus_a.readdata, vt[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'h0, irq_a}, {31'h0, vt[i].exp_irq});
        end

        // Falling edge ignored, rising edge captured at t+3, irq at t+4
        drive_a(2'd2, 1'b1, 32'h8); tick();
        drive_a(2'd3, 1'b0, 32'h0);
        in_a = 24'hFFFFF7;
        repeat (6) tick();
        $display("seq fall bit3: rd=%h irq=%0b", bus_a.readdata, irq_a);
        check("fall_nocap", bus_a.readdata, 32'h0);
        check("fall_noirq", {31'h0, irq_a}, 32'h0);
        in_a = 24'hFFFFFF;
        repeat (3) tick();
        check("rise_t3_rd", bus_a.readdata, 32'h0);
        check("rise_t3_irq", {31'h0, irq_a}, 32'h0);
        tick();
        $display("seq rise bit3: rd=%h irq=%0b", bus_a.readdata, irq_a);
        check("rise_cap", bus_a.readdata, 32'h8);
        check("rise_irq", {31'h0, irq_a}, 32'h1);

        // Clear coincident with a new event: set wins
        in_a = 24'hFFFFF7;
        repeat (4) tick();
        in_a = 24'hFFFFFF;
        repeat (2) tick();
        drive_a(2'd3, 1'b1, 32'h8); tick();
        check("setwin_irq0", {31'h0, irq_a}, 32'h1);
        drive_a(2'd3, 1'b0, 32'h0); tick();
        $display("seq set-wins: rd=%h irq=%0b", bus_a.readdata, irq_a);
        check("setwin_rd", bus_a.readdata, 32'h8);
        check("setwin_irq1", {31'h0, irq_a}, 32'h1);

        // Plain clear: irq drops one cycle later
        drive_a(2'd3, 1'b1, 32'h8); tick();
        check("clr_irq_hold", {31'h0, irq_a}, 32'h1);
        drive_a(2'd3, 1'b0, 32'h0); tick();
        $display("seq clear: rd=%h irq=%0b", bus_a.readdata, irq_a);
        check("clr_rd", bus_a.readdata, 32'h0);
        check("clr_irq_drop", {31'h0, irq_a}, 32'h0);

        // Masked capture, then unmask all
        drive_a(2'd2, 1'b1, 32'h0); tick();
        drive_a(2'd3, 1'b0, 32'h0);
        in_a = 24'hFFFFF7; repeat (3) tick();
        in_a = 24'hFFFFFF; repeat (5) tick();
        check("mask0_cap", bus_a.readdata, 32'h8);
        check("mask0_irq", {31'h0, irq_a}, 32'h0);
        drive_a(2'd2, 1'b1, 32'hFFFFFFFF); tick();
        check("mask_wr_irq", {31'h0, irq_a}, 32'h0);
        drive_a(2'd2, 1'b0, 32'h0); tick();
        $display("seq mask all: rd=%h irq=%0b", bus_a.readdata, irq_a);
        check("mask_all_irq", {31'h0, irq_a}, 32'h1);
        check("mask_rb", bus_a.readdata, 32'h00FFFFFF);

        // Second instance: any-edge, 3 stages, reset mid-toggle and re-priming
        rst_b_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_b[0] = ~in_b[0];
            tick();
        end
        check("b_cap_pre", bus_b.readdata, 32'h1);
        rst_b_n = 1'b0;
        #1;
        check("b_rst_rd", bus_b.readdata, 32'h0);
        check("b_rst_irq", {31'h0, irq_b}, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            in_b[0] = ~in_b[0];
            tick();
        end
        rst_b_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            in_b[0] = ~in_b[0];
            tick();
            $display("seq B prime edge %0d: rd=%h irq=%0b", n, bus_b.readdata, irq_b);
            check($sformatf("b_prime%0d", n), bus_b.readdata, (n >= 6) ? 32'h1 : 32'h0);
        end
        check("b_irq_masked", {31'h0, irq_b}, 32'h0);

        // Randomized traffic against the model, with occasional resets
        rst_a_n = 1'b0; model_reset();
        tick();
        rst_a_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0)
                in_a = in_a ^ (W'($urandom) & W'($urandom) & W'($urandom));
            bus_a.address    = 2'($urandom_range(0, 3));
            bus_a.chipselect = 1'($urandom_range(0, 1));
            bus_a.write_n    = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
            bus_a.writedata  = $urandom;
            if (bus_a.chipselect && !bus_a.write_n)
                $display("rand wr addr=%0d data=%h", bus_a.address, bus_a.writedata);
            if ($urandom_range(0, 149) == 0) begin
                rst_a_n = 1'b0; model_reset();
            end else begin
                rst_a_n = 1'b1;
            end
            tick();
            check("rand_rd", bus_a.readdata, m_rd);
            check("rand_irq", {31'h0, irq_a}, {31'h0, m_irq});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
